// File: rtl/pon_burst_framer.sv
// Burst delineator for the PON upstream receiver: syncword, header, payload, guard.
// Define BURST_FRAMER_BIP_EN to add the BIP-8 trailer check (out_bip_err is tied low otherwise).
module pon_burst_framer #(
    parameter int DETECT_DELAY      = 8,
    parameter int MAX_PAYLOAD_WORDS = 256,
    parameter int GUARD_WORDS       = 4
) (
    input  logic        in_clock,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_detected,
    output logic        out_sync_enable,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic [7:0]  out_onu_id,
    output logic        out_len_err,
    output logic        out_bip_err,
    output logic [15:0] out_burst_count
);

`ifdef BURST_FRAMER_BIP_EN
    typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, GUARD, TRAILER} state_t;
`else
    typedef enum logic [2:0] {HUNT, HEADER, PAYLOAD, GUARD} state_t;
`endif

    localparam logic [15:0] MAX_LEN    = 16'(MAX_PAYLOAD_WORDS);
    localparam logic [7:0]  GUARD_LAST = 8'(GUARD_WORDS - 1);

    state_t      state;
    logic [15:0] remaining;
    logic [7:0]  guard_cnt;
    logic        first;
    logic        det_d;
    logic [15:0] hdr_len;

    assign hdr_len = in_data[15:0];

    // Align the detect flag with the syncword word on in_data.
    generate
        if (DETECT_DELAY == 0) begin : g_no_delay
            assign det_d = in_detected;
        end else begin : g_delay
            logic [DETECT_DELAY-1:0] det_q;
            always_ff @(posedge in_clock) begin
                if (!rst) begin
                    det_q <= '0;
                end else begin
                    det_q[0] <= in_detected;
                    for (int i = 1; i < DETECT_DELAY; i++) begin
                        det_q[i] <= det_q[i-1];
                    end
                end
            end
            assign det_d = det_q[DETECT_DELAY-1];
        end
    endgenerate

`ifdef BURST_FRAMER_BIP_EN
    logic [7:0] bip;
`endif

    always_ff @(posedge in_clock) begin
        if (!rst) begin
            state           <= HUNT;
            remaining       <= '0;
            guard_cnt       <= '0;
            first           <= 1'b0;
            out_sync_enable <= 1'b1;
            out_data        <= '0;
            out_valid       <= 1'b0;
            out_sof         <= 1'b0;
            out_eof         <= 1'b0;
            out_onu_id      <= '0;
            out_len_err     <= 1'b0;
            out_burst_count <= '0;
`ifdef BURST_FRAMER_BIP_EN
            bip             <= '0;
            out_bip_err     <= 1'b0;
`endif
        end else begin
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_eof     <= 1'b0;
            out_len_err <= 1'b0;
`ifdef BURST_FRAMER_BIP_EN
            out_bip_err <= 1'b0;
`endif
            case (state)
                HUNT: begin
                    if (det_d) begin
                        state           <= HEADER;
                        out_sync_enable <= 1'b0;
                    end
                end
                HEADER: begin
                    if (hdr_len == 16'd0 || hdr_len > MAX_LEN) begin
                        out_len_err <= 1'b1;
                        guard_cnt   <= GUARD_LAST;
                        state       <= GUARD;
                    end else begin
                        out_onu_id <= in_data[31:24];
                        remaining  <= hdr_len;
                        first      <= 1'b1;
                        state      <= PAYLOAD;
                    end
`ifdef BURST_FRAMER_BIP_EN
                    bip <= '0;
`endif
                end
                PAYLOAD: begin
                    out_valid <= 1'b1;
                    out_data  <= in_data;
                    out_sof   <= first;
                    first     <= 1'b0;
                    remaining <= remaining - 16'd1;
`ifdef BURST_FRAMER_BIP_EN
                    bip <= bip ^ in_data[31:24] ^ in_data[23:16] ^ in_data[15:8] ^ in_data[7:0];
`endif
                    if (remaining == 16'd1) begin
                        out_eof         <= 1'b1;
                        out_burst_count <= out_burst_count + 16'd1;
                        guard_cnt       <= GUARD_LAST;
`ifdef BURST_FRAMER_BIP_EN
                        state <= TRAILER;
`else
                        state <= GUARD;
`endif
                    end
                end
`ifdef BURST_FRAMER_BIP_EN
                TRAILER: begin
                    out_bip_err <= (in_data[7:0] != bip);
                    guard_cnt   <= GUARD_LAST;
                    state       <= GUARD;
                end
`endif
                GUARD: begin
                    // The detect flag is not looked at here, including on the last guard cycle.
                    if (guard_cnt == 8'd0) begin
                        state           <= HUNT;
                        out_sync_enable <= 1'b1;
                    end else begin
                        guard_cnt <= guard_cnt - 8'd1;
                    end
                end
                default: begin
                    state           <= HUNT;
                    out_sync_enable <= 1'b1;
                end
            endcase
        end
    end

`ifndef BURST_FRAMER_BIP_EN
    assign out_bip_err = 1'b0;
`endif

endmodule

// File: tb/tb_pon_burst_framer.sv
// Directed bench for pon_burst_framer: table of burst records plus hand-written
// sequences for spurious detects, reset mid-burst and (with BURST_FRAMER_BIP_EN) the BIP trailer.
module tb_pon_burst_framer;

    localparam int DD   = 8;
    localparam int MAXL = 256;
    localparam int GW   = 4;
`ifdef BURST_FRAMER_BIP_EN
    localparam int TRL = 1;
`else
    localparam int TRL = 0;
`endif
    localparam logic [31:0] SYNC = 32'hB5A3_C0DE;

    logic        in_clock = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_detected = 1'b0;
    logic        out_sync_enable;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_onu_id;
    logic        out_len_err;
    logic        out_bip_err;
    logic [15:0] out_burst_count;

    pon_burst_framer #(
        .DETECT_DELAY(DD),
        .MAX_PAYLOAD_WORDS(MAXL),
        .GUARD_WORDS(GW)
    ) dut (
        .in_clock(in_clock),
        .rst(rst),
        .in_data(in_data),
        .in_detected(in_detected),
        .out_sync_enable(out_sync_enable),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_sof(out_sof),
        .out_eof(out_eof),
        .out_onu_id(out_onu_id),
        .out_len_err(out_len_err),
        .out_bip_err(out_bip_err),
        .out_burst_count(out_burst_count)
    );

    always #5 in_clock = ~in_clock;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_onu = '0;
    logic [15:0] exp_count = '0;

    typedef struct {
        logic [7:0]  onu;
        logic [7:0]  rsv;
        int          len;
        logic [31:0] base;
        logic [31:0] step;
        bit          bad;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int c, input logic sync_en, input logic valid,
                           input logic sof, input logic eof, input logic [31:0] data,
                           input logic len_err, input logic bip_err, input logic [15:0] count);
        chk($sformatf("%s c%0d sync_enable", tag, c), 32'(out_sync_enable), 32'(sync_en));
        chk($sformatf("%s c%0d valid", tag, c), 32'(out_valid), 32'(valid));
        chk($sformatf("%s c%0d sof", tag, c), 32'(out_sof), 32'(sof));
        chk($sformatf("%s c%0d eof", tag, c), 32'(out_eof), 32'(eof));
        chk($sformatf("%s c%0d len_err", tag, c), 32'(out_len_err), 32'(len_err));
        chk($sformatf("%s c%0d bip_err", tag, c), 32'(out_bip_err), 32'(bip_err));
        chk($sformatf("%s c%0d burst_count", tag, c), 32'(out_burst_count), 32'(count));
        if (valid) chk($sformatf("%s c%0d data", tag, c), out_data, data);
    endtask

    // Detect pulse, delay, syncword, header; returns at the first cycle after the header.
    task automatic start_burst(input string tag, input logic [31:0] hdr);
        in_detected = 1'b1;
        in_data     = '0;
        tick();
        in_detected = 1'b0;
        repeat (DD - 1) tick();
        chk({tag, " hunt sync_enable"}, 32'(out_sync_enable), 32'd1);
        in_data = SYNC;
        tick();
        chk({tag, " header sync_enable"}, 32'(out_sync_enable), 32'd0);
        in_data = hdr;
        tick();
    endtask

    task automatic run_burst(input string tag, input vec_t v, input logic [7:0] corrupt, input bit spur);
        int          last;
        int          spur_c;
        logic [7:0]  bip;
        logic [31:0] w;
        logic [31:0] pw;
        bip    = '0;
        last   = v.bad ? GW : v.len + TRL + GW;
        spur_c = v.len + TRL + GW - 1 - DD;
        start_burst(tag, {v.onu, v.rsv, 16'(v.len)});
        for (int c = 0; c <= last; c++) begin
            if (v.bad) begin
                chk_out(tag, c, c == last, 1'b0, 1'b0, 1'b0, '0, c == 0, 1'b0, exp_count);
            end else begin
                pw = v.base + v.step * 32'(c - 1);
                chk_out(tag, c, c == last, c >= 1 && c <= v.len, c == 1, c == v.len, pw, 1'b0,
                        TRL == 1 && c == v.len + 1 && corrupt != 8'd0,
                        16'(exp_count + 16'(c >= v.len)));
            end
            w = v.base + v.step * 32'(c);
            if (!v.bad && c < v.len) begin
                in_data = w;
                bip = bip ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            end else if (!v.bad && TRL == 1 && c == v.len) begin
                in_data = {24'h0, bip ^ corrupt};
            end else begin
                in_data = '0;
            end
            in_detected = spur && (c == 0 || c == spur_c);
            tick();
        end
        in_detected = 1'b0;
        in_data     = '0;
        if (!v.bad) begin
            exp_count = exp_count + 16'd1;
            exp_onu   = v.onu;
        end
        chk({tag, " onu_id"}, 32'(out_onu_id), 32'(exp_onu));
        // Nothing may restart until a fresh detect arrives.
        for (int c = 0; c < DD + 4; c++) begin
            chk_out({tag, " idle"}, c, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, exp_count);
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sp;
        vecs[0] = '{8'h2A, 8'h00, 3,      32'h11111111, 32'h11111111, 1'b0};
        vecs[1] = '{8'h05, 8'hA5, 1,      32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[2] = '{8'h99, 8'h00, 0,      32'h00000000, 32'h00000000, 1'b1};
        vecs[3] = '{8'h98, 8'h00, MAXL+1, 32'h00000000, 32'h00000000, 1'b1};
        vecs[4] = '{8'h3C, 8'hFF, MAXL,   32'h00000000, 32'h00000001, 1'b0};
        vecs[5] = '{8'h81, 8'h12, 2,      32'hCAFEF00D, 32'h01010101, 1'b0};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", i, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 16'd0);
            chk($sformatf("reset c%0d data", i), out_data, 32'd0);
            chk($sformatf("reset c%0d onu_id", i), 32'(out_onu_id), 32'd0);
        end
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i], 8'd0, 1'b0);
        end

        sp = '{8'h6B, 8'h00, 12, 32'h0F0F0000, 32'h00000101, 1'b0};
        run_burst("spurious", sp, 8'd0, 1'b1);

`ifdef BURST_FRAMER_BIP_EN
        sp = '{8'h44, 8'h00, 1, 32'h01020304, 32'h00000000, 1'b0};
        run_burst("bip_ok", sp, 8'd0, 1'b0);
        run_burst("bip_bad", sp, 8'd1, 1'b0);
`endif

        // Reset on the second payload word of an L=5 burst; a detect already in the delay line must die too.
        start_burst("midrst", {8'h77, 8'h00, 16'd5});
        in_data     = 32'hA0000000;
        in_detected = 1'b1;
        tick();
        chk("midrst first valid", 32'(out_valid), 32'd1);
        chk("midrst first sof", 32'(out_sof), 32'd1);
        in_data     = 32'hA0000001;
        in_detected = 1'b0;
        rst         = 1'b0;
        tick();
        rst       = 1'b1;
        exp_count = '0;
        exp_onu   = '0;
        chk_out("midrst after", 0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 16'd0);
        chk("midrst onu_id", 32'(out_onu_id), 32'd0);
        for (int c = 1; c < 14; c++) begin
            in_data = (c < 4) ? 32'hA0000001 + 32'(c) : 32'd0;
            tick();
            chk_out("midrst hunt", c, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 16'd0);
        end
        in_data = '0;
        run_burst("recover", vecs[0], 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pon_burst_framer.md
Name: pon_burst_framer

Overview:
- Downstream of the burst-mode synchronizer in the PON upstream receive path.
- Consumes bit-aligned 32-bit words and the syncword-detected flag, then delineates one burst: syncword, header, then payload.
- Emits payload words with valid/SOF/EOF and the ONU ID, and gates the synchronizer's shift-update enable so alignment is frozen for the duration of a burst.

Parameters:
DETECT_DELAY, 8, cycles from in_detected high to the matching syncword word appearing on in_data (range 0..15)
MAX_PAYLOAD_WORDS, 256, largest legal header length field, in words
GUARD_WORDS, 4, idle cycles after a burst before hunting resumes (range 1..255)

Ports:
in_clock  in  1  clock
rst  in  1  reset, synchronous, active-low
in_data  in  32  aligned data from burst synchronizer
in_detected  in  1  syncword detected, from synchronizer
out_sync_enable  out  1  drives synchronizer shift-update enable
out_data  out  32  payload word
out_valid  out  1  out_data valid
out_sof  out  1  first payload word of burst
out_eof  out  1  last payload word of burst
out_onu_id  out  8  ONU ID of current burst, held until next header
out_len_err  out  1  one-cycle pulse, illegal header length
out_bip_err  out  1  one-cycle pulse, BIP mismatch (optional feature)
out_burst_count  out  16  completed bursts, wraps at 0xFFFF

Behaviour:
- Reset (rst==0 at a clock edge): state HUNT; detect delay line cleared; all outputs 0 except out_sync_enable=1. Reset mid-burst aborts immediately with no EOF.
- det_d = in_detected delayed by DETECT_DELAY registers. With DETECT_DELAY=0, det_d is in_detected directly.
- Header word layout: [31:24] ONU ID, [23:16] reserved (ignored), [15:0] payload length L in words.
- HUNT:
  - out_sync_enable=1.
  - det_d==1 marks the syncword cycle; next state is HEADER.
- HEADER (1 cycle, in_data is the header word):
  - out_sync_enable=0.
  - If L==0 or L>MAX_PAYLOAD_WORDS: pulse out_len_err, go to GUARD.
  - Otherwise: latch out_onu_id, load remaining-word counter with L, go to PAYLOAD.
- PAYLOAD:
  - Each cycle: out_valid=1, out_data=in_data, counter decrements.
  - out_sof on the first word; out_eof on the word where counter==1.
  - For L==1, SOF and EOF are asserted together.
  - After EOF: increment out_burst_count, go to GUARD (or TRAILER, see Optional Feature).
- GUARD:
  - Counts GUARD_WORDS cycles with out_sync_enable=0.
  - Then HUNT, with out_sync_enable=1 on the first HUNT cycle.
- Data-path timing:
  - out_data, out_valid, out_sof and out_eof are registered: one cycle of latency from in_data.
  - Pulse outputs out_len_err and out_bip_err are registered and high for exactly 1 cycle.
- det_d outside HUNT is ignored; no re-sync mid-burst.
- det_d on the last GUARD cycle is also ignored.
- out_onu_id is updated only on a legal header.
- out_burst_count is not incremented on a length error.
- Counter width is 16 bits, so there is no wrap inside a legal burst.

Optional Feature:
- Macro BURST_FRAMER_BIP_EN.
- Defined:
  - A running BIP-8 (XOR of all four bytes of every payload word) is accumulated during PAYLOAD.
  - After EOF the FSM enters TRAILER for 1 cycle; out_valid=0 in that cycle.
  - in_data[7:0] is compared with the accumulator; a mismatch pulses out_bip_err one cycle later.
  - BIP is cleared in HEADER.
  - Then GUARD.
- Undefined: no TRAILER state, no accumulator, out_bip_err tied to 0.

Test Plan:
- Basic burst: rst low 3 cycles then high; in_detected pulse; DETECT_DELAY=8 cycles later in_data=syncword, then header 0x2A000003, then payload 0x11111111, 0x22222222, 0x33333333 -> out_valid for 3 cycles, SOF on 0x11111111, EOF on 0x33333333, out_onu_id=0x2A, out_burst_count=1, out_sync_enable low from HEADER through GUARD end.
- Single-word burst: header L=1, payload 0xDEADBEEF -> SOF and EOF in the same cycle; 4 guard cycles, then out_sync_enable=1.
- Length errors: header L=0 -> out_len_err 1-cycle pulse, no out_valid, count unchanged; header L=257 -> same response.
- Spurious detect: in_detected pulses during PAYLOAD and GUARD -> ignored, burst completes normally with L words output.
- Reset mid-burst: rst=0 on the 2nd payload word of an L=5 burst -> next cycle out_valid=0, out_eof never asserted, state HUNT, out_sync_enable=1.
- BIP (macro defined): payload 0x01020304 then trailer 0x00000004 -> no out_bip_err; trailer 0x00000005 -> out_bip_err pulse one cycle after the trailer.
